// File: rtl/multi_signal_sync.sv
// -----------------------------------------------------------------------------
// multi_signal_sync
//   Per-channel synchronizer for asynchronous level inputs. Each channel runs
//   through a SYNC_STAGES-deep flop chain and then a glitch filter, which
//   accepts a new level only after it has been stable for FILTER_CNT cycles.
//   An accepted level change that matches EDGE_MODE produces a one-cycle
//   registered pulse and sets a sticky event flag.
//
// Parameters
//   N_CH        number of independent channels (1..32)
//   SYNC_STAGES synchronizer depth (2..4)
//   FILTER_CNT  stable cycles needed to accept a level (1..255, 1 = no filter)
//   EDGE_MODE   0 = rising, 1 = falling, 2 = both
//   INIT_VAL    per-channel reset level
//
// Ports
//   clk_b       clock, all logic is in this domain
//   rst_b       synchronous active-high reset
//   sig_in      asynchronous level inputs
//   evt_clr     per-channel clear of evt_flag
//   sig_sync    synchronized, filtered level
//   pulse_sync  one-cycle pulse on a qualified level change
//   evt_flag    sticky event flag
// -----------------------------------------------------------------------------
module multi_signal_sync #(
  parameter int              N_CH        = 4,
  parameter int              SYNC_STAGES = 2,
  parameter int              FILTER_CNT  = 1,
  parameter int              EDGE_MODE   = 0,
  parameter logic [N_CH-1:0] INIT_VAL    = '0
) (
  input  logic            clk_b,
  input  logic            rst_b,
  input  logic [N_CH-1:0] sig_in,
  input  logic [N_CH-1:0] evt_clr,
  output logic [N_CH-1:0] sig_sync,
  output logic [N_CH-1:0] pulse_sync,
  output logic [N_CH-1:0] evt_flag
);

  localparam int             CNT_W    = $clog2(FILTER_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CNT - 1);

  // Whether a transition to new_lvl is a qualified edge.
  function automatic logic edge_ok(input logic new_lvl);
    if (EDGE_MODE == 0)      return new_lvl;
    else if (EDGE_MODE == 1) return !new_lvl;
    else                     return 1'b1;
  endfunction

  // ---- stage p0: synchronizer chain ----
  (* ASYNC_REG = "TRUE", keep = "true", preserve = "true" *)
  logic [N_CH-1:0] sync_p0 [SYNC_STAGES];
  logic [N_CH-1:0] s_p0;

  assign s_p0 = sync_p0[SYNC_STAGES-1];

  always_ff @(posedge clk_b) begin
    if (rst_b) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_p0[k] <= INIT_VAL;
    end else begin
      sync_p0[0] <= sig_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_p0[k] <= sync_p0[k-1];
    end
  end

  // ---- stage p1: glitch filter, pulse and sticky flag ----
  logic [N_CH-1:0]  lvl_p1;
  logic [CNT_W-1:0] cnt_p1 [N_CH];
  logic [N_CH-1:0]  pulse_p1;
  logic [N_CH-1:0]  flag_p1;
  logic [N_CH-1:0]  accept;
  logic [N_CH-1:0]  pulse_nxt;

  always_comb begin
    accept    = '0;
    pulse_nxt = '0;
    for (int i = 0; i < N_CH; i++) begin
      accept[i]    = (s_p0[i] != lvl_p1[i]) && (cnt_p1[i] == CNT_LAST);
      pulse_nxt[i] = accept[i] && edge_ok(s_p0[i]);
    end
  end

  always_ff @(posedge clk_b) begin
    if (rst_b) begin
      lvl_p1   <= INIT_VAL;
      pulse_p1 <= '0;
      flag_p1  <= '0;
      for (int i = 0; i < N_CH; i++) cnt_p1[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (s_p0[i] == lvl_p1[i]) begin
          cnt_p1[i] <= '0;
        end else if (accept[i]) begin
          lvl_p1[i] <= s_p0[i];
          cnt_p1[i] <= '0;
        end else begin
          // Cannot overflow: at CNT_LAST with a differing level we accept.
          cnt_p1[i] <= cnt_p1[i] + CNT_W'(1);
        end
      end
      pulse_p1 <= pulse_nxt;
      // The flag rises together with the pulse, and a clear arriving while
      // the pulse is still visible on pulse_sync loses to it.
      flag_p1  <= pulse_nxt | pulse_p1 | (flag_p1 & ~evt_clr);
    end
  end

  assign sig_sync   = lvl_p1;
  assign pulse_sync = pulse_p1;
  assign evt_flag   = flag_p1;

endmodule

// File: tb/tb_multi_signal_sync.sv
module tb_multi_signal_sync;

  logic clk_b = 1'b0;
  always #5 clk_b = ~clk_b;

  int n_cmp = 0;
  int n_bad = 0;

  // dut0: defaults with FILTER_CNT=3, rising edges
  logic       rst0;
  logic [3:0] sin0, clr0, sync0, pls0, flg0;
  // dut1 / dut2: falling / both edges, shared stimulus
  logic       rst_e;
  logic [3:0] sin_e, clr_e, sync1, pls1, flg1, sync2, pls2, flg2;
  // dut3: INIT_VAL all ones
  logic       rst3;
  logic [3:0] sin3, clr3, sync3, pls3, flg3;

  multi_signal_sync #(.N_CH(4), .SYNC_STAGES(2), .FILTER_CNT(3), .EDGE_MODE(0),
                      .INIT_VAL(4'b0000)) dut0 (
    .clk_b(clk_b), .rst_b(rst0), .sig_in(sin0), .evt_clr(clr0),
    .sig_sync(sync0), .pulse_sync(pls0), .evt_flag(flg0));

  multi_signal_sync #(.N_CH(4), .SYNC_STAGES(2), .FILTER_CNT(3), .EDGE_MODE(1),
                      .INIT_VAL(4'b0000)) dut1 (
    .clk_b(clk_b), .rst_b(rst_e), .sig_in(sin_e), .evt_clr(clr_e),
    .sig_sync(sync1), .pulse_sync(pls1), .evt_flag(flg1));

  multi_signal_sync #(.N_CH(4), .SYNC_STAGES(2), .FILTER_CNT(3), .EDGE_MODE(2),
                      .INIT_VAL(4'b0000)) dut2 (
    .clk_b(clk_b), .rst_b(rst_e), .sig_in(sin_e), .evt_clr(clr_e),
    .sig_sync(sync2), .pulse_sync(pls2), .evt_flag(flg2));

  multi_signal_sync #(.N_CH(4), .SYNC_STAGES(2), .FILTER_CNT(3), .EDGE_MODE(0),
                      .INIT_VAL(4'b1111)) dut3 (
    .clk_b(clk_b), .rst_b(rst3), .sig_in(sin3), .evt_clr(clr3),
    .sig_sync(sync3), .pulse_sync(pls3), .evt_flag(flg3));

  typedef struct {
    logic [3:0] sin;
    logic [3:0] clr;
    logic [3:0] e_sync;
    logic [3:0] e_pls;
    logic [3:0] e_flg;
  } vec_t;

  vec_t tbl [25];

  task automatic tick();
    @(posedge clk_b);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  int cnt1, cnt2, pos1, pos2a, pos2b;

  initial begin
    // Row: inputs applied before an edge, outputs expected just after it.
    // ch0 step (rows 0-4), flag collision/clear (5-8), ch1 2-cycle glitch
    // (9-15), ch1 3-cycle pulse accepted then dropped (16-24).
    tbl[0]  = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[1]  = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[2]  = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[3]  = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[4]  = '{4'h1, 4'h0, 4'h1, 4'h1, 4'h1};
    tbl[5]  = '{4'h1, 4'h1, 4'h1, 4'h0, 4'h1};
    tbl[6]  = '{4'h1, 4'h1, 4'h1, 4'h0, 4'h0};
    tbl[7]  = '{4'h1, 4'h1, 4'h1, 4'h0, 4'h0};
    tbl[8]  = '{4'h1, 4'h0, 4'h1, 4'h0, 4'h0};
    tbl[9]  = '{4'h3, 4'h0, 4'h1, 4'h0, 4'h0};
    tbl[10] = '{4'h3, 4'h0, 4'h1, 4'h0, 4'h0};
    tbl[11] = '{4'h1, 4'h0, 4'h1, 4'h0, 4'h0};
    tbl[12] = '{4'h1, 4'h0, 4'h1, 4'h0, 4'h0};
    tbl[13] = '{4'h1, 4'h0, 4'h1, 4'h0, 4'h0};
    tbl[14] = '{4'h1, 4'h0, 4'h1, 4'h0, 4'h0};
    tbl[15] = '{4'h1, 4'h0, 4'h1, 4'h0, 4'h0};
    tbl[16] = '{4'h3, 4'h0, 4'h1, 4'h0, 4'h0};
    tbl[17] = '{4'h3, 4'h0, 4'h1, 4'h0, 4'h0};
    tbl[18] = '{4'h3, 4'h0, 4'h1, 4'h0, 4'h0};
    tbl[19] = '{4'h1, 4'h0, 4'h1, 4'h0, 4'h0};
    tbl[20] = '{4'h1, 4'h0, 4'h3, 4'h2, 4'h2};
    tbl[21] = '{4'h1, 4'h0, 4'h3, 4'h0, 4'h2};
    tbl[22] = '{4'h1, 4'h0, 4'h3, 4'h0, 4'h2};
    tbl[23] = '{4'h1, 4'h0, 4'h1, 4'h0, 4'h2};
    tbl[24] = '{4'h1, 4'h0, 4'h1, 4'h0, 4'h2};

    rst0 = 1'b1; sin0 = 4'hF; clr0 = 4'hF;
    rst_e = 1'b1; sin_e = 4'h0; clr_e = 4'h0;
    rst3 = 1'b1; sin3 = 4'hF; clr3 = 4'h0;

    // Reset holds everything at INIT_VAL despite active sig_in / evt_clr.
    repeat (3) tick();
    chk("reset sync0", 32'(sync0), 32'h0);
    chk("reset pulse0", 32'(pls0), 32'h0);
    chk("reset flag0", 32'(flg0), 32'h0);
    chk("reset sync3", 32'(sync3), 32'hF);
    sin0 = 4'h0; clr0 = 4'h0;
    tick();
    rst0 = 1'b0;

    // Table-driven vectors on dut0.
    for (int i = 0; i < 25; i++) begin
      sin0 = tbl[i].sin;
      clr0 = tbl[i].clr;
      tick();
      chk($sformatf("vec%0d sync", i),  32'(sync0), 32'(tbl[i].e_sync));
      chk($sformatf("vec%0d pulse", i), 32'(pls0),  32'(tbl[i].e_pls));
      chk($sformatf("vec%0d flag", i),  32'(flg0),  32'(tbl[i].e_flg));
    end

    // Reset mid-count: ch3 rises at edge k, reset sampled at edge k+3.
    sin0 = 4'b1001; clr0 = 4'h0;
    tick();
    chk("midrst k sync", 32'(sync0), 32'h1);
    tick(); tick();
    chk("midrst k+2 sync", 32'(sync0), 32'h1);
    rst0 = 1'b1;
    tick();
    rst0 = 1'b0;
    chk("midrst k+3 sync", 32'(sync0), 32'h0);
    chk("midrst k+3 flag", 32'(flg0), 32'h0);
    for (int t = 4; t <= 7; t++) begin
      tick();
      chk($sformatf("midrst k+%0d sync", t), 32'(sync0), 32'h0);
      chk($sformatf("midrst k+%0d pulse", t), 32'(pls0), 32'h0);
    end
    tick();
    chk("midrst k+8 sync", 32'(sync0), 32'h9);
    chk("midrst k+8 pulse", 32'(pls0), 32'h9);
    tick();
    chk("midrst k+9 pulse", 32'(pls0), 32'h0);
    chk("midrst k+9 flag", 32'(flg0), 32'h9);

    // Edge modes: ch2 rises (held 8 cycles) then falls.
    tick();
    rst_e = 1'b0;
    cnt1 = 0; cnt2 = 0; pos1 = -1; pos2a = -1; pos2b = -1;
    for (int t = 0; t < 24; t++) begin
      sin_e = (t < 8) ? 4'b0100 : 4'b0000;
      tick();
      if (t == 4) chk("mode1 sync after rise", 32'(sync1), 32'h4);
      if (pls1[2]) begin cnt1++; pos1 = t; end
      if (pls2[2]) begin
        cnt2++;
        if (pos2a < 0) pos2a = t; else pos2b = t;
      end
    end
    chk("mode1 pulse count", 32'(cnt1), 32'd1);
    chk("mode1 pulse cycle", 32'(pos1), 32'd12);
    chk("mode2 pulse count", 32'(cnt2), 32'd2);
    chk("mode2 rise cycle", 32'(pos2a), 32'd4);
    chk("mode2 fall cycle", 32'(pos2b), 32'd12);
    chk("mode1 flag", 32'(flg1), 32'h4);

    // INIT_VAL all ones with inputs high across reset release.
    rst3 = 1'b0;
    for (int t = 0; t < 20; t++) begin
      tick();
      chk($sformatf("init c%0d pulse", t), 32'(pls3), 32'h0);
      chk($sformatf("init c%0d flag", t),  32'(flg3), 32'h0);
      chk($sformatf("init c%0d sync", t),  32'(sync3), 32'hF);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
